em_skid_stage: RTL and testbench
================================

# em_skid_stage

Parametrised EX/MEM boundary register with a valid/ready handshake and a two-entry skid buffer. It replaces the free-running EX/MEM latch so that memory-stage backpressure (a stalled data memory) holds the result without a combinational ready path back into execute. It supports a flush that kills in-flight entries. Architectural side-effect controls (RegWriteM, MemWriteM) are gated by the valid bit.

## Interface
Parameters:
- XLEN, 32, width of ALUResult, WriteData, PCPlus4
- REG_AW, 5, register-address width (Rd)
- RSRC_W, 2, ResultSrc width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- FlushM  in  1  synchronous kill of all held entries
- ValidE  in  1  execute stage presents an entry
- ReadyE  out  1  stage can accept; driven directly from a flop (no combinational input path)
- RegWriteE, MemWriteE  in  1 each  control bits
- ResultSrcE  in  RSRC_W
- ALUResultE, WriteDataE, PCPlus4E  in  XLEN each
- RdE  in  REG_AW
- ValidM  out  1  main register holds a live entry
- ReadyM  in  1  memory stage consumes the entry this cycle
- RegWriteM, MemWriteM  out  1 each  stored bit AND ValidM
- ResultSrcM  out  RSRC_W
- ALUResultM, WriteDataM, PCPlus4M  out  XLEN each
- RdM  out  REG_AW
- OccM  out  2  entries held: 0, 1 or 2

## Operation
- Storage: main register (drives the M outputs) and skid register, each with a valid flag (mv, sv).
- Invariant: sv=1 implies mv=1.
- Accept = ValidE & ReadyE. Consume = mv & ReadyM.
- ReadyE = ~sv, registered.
- Update rules when FlushM=0:
  - mv=0: on Accept, main <= E inputs and mv <= 1.
  - mv=1, sv=0, Consume: main <= E inputs on Accept; otherwise mv <= 0.
  - mv=1, sv=0, no Consume, Accept: skid <= E inputs and sv <= 1.
  - mv=1, sv=1, Consume: main <= skid and sv <= 0. ReadyE was 0, so nothing is accepted this cycle.
  - mv=1, sv=1, no Consume: hold both.
- FlushM=1: mv <= 0 and sv <= 0. Flush overrides Accept and Consume. The entry offered in that cycle is dropped, but the producer sees the handshake complete if ReadyE=1.
- Data registers keep stale contents when invalid. Only the RegWriteM/MemWriteM gating is architecturally visible.
- OccM = mv + sv.
- Reset (async assert, sync release): mv=0, sv=0, all data/control registers 0. After reset, ReadyE=1, ValidM=0, RegWriteM=0, MemWriteM=0, all M buses 0, OccM=0.

## Timing
- Latency: an entry accepted at edge N appears at the M outputs after edge N with ValidM=1 (1 cycle).
- Throughput: 1 entry/cycle while ReadyM=1.
- Backpressure:
  - ReadyM dropping while full absorbs at most one extra entry into the skid register.
  - ReadyE falls the cycle after the skid register fills.
  - ReadyE rises the cycle after the skid register drains into main.
- Ordering is strictly FIFO. No entry is duplicated or lost except by FlushM.
- Producer must hold its E inputs stable while ValidE=1 and ReadyE=0. Consumer may change ReadyM freely.
- rst_n asserted mid-operation clears all state immediately, without waiting for a clock edge. Outputs reach reset values within the same cycle.

## Test plan
- Reset then stream:
  - Stimulus: rst_n low, then high; drive ALUResultE=0x10,0x20,0x30 on consecutive cycles with ValidE=1, ReadyM=1.
  - Response: ValidM rises one cycle after the first accept; ALUResultM shows 0x10,0x20,0x30 on consecutive cycles; OccM=1 throughout; ReadyE=1 throughout.
- Backpressure skid:
  - Stimulus: stream 0xA,0xB,0xC,0xD with ReadyM=0 from the cycle after 0xA lands in main.
  - Response: main holds 0xA; skid takes 0xB; ReadyE=0 next cycle; 0xC is held by the producer; OccM=2.
  - Stimulus: release ReadyM.
  - Response: outputs 0xA,0xB,0xC,0xD in order, no gaps after the ReadyE recovery cycle.
- Gating:
  - Stimulus: MemWriteE=1, RegWriteE=1, RdE=5 with ValidE=0.
  - Response: MemWriteM=0 and RegWriteM=0 regardless of stored bits.
  - Stimulus: the same with ValidE=1.
  - Response: both bits are 1 for exactly one cycle under ReadyM=1.
- Flush:
  - Stimulus: with OccM=2, assert FlushM together with ValidE=1 and ReadyM=1.
  - Response: next cycle ValidM=0, OccM=0, ReadyE=1, MemWriteM=0; the offered entry never appears.
- Async reset mid-stall:
  - Stimulus: OccM=2, ReadyM=0; pulse rst_n low between clock edges.
  - Response: ValidM=0, OccM=0, ReadyE=1, all M buses 0 before the next edge.
- Randomised ValidE/ReadyM, 10k cycles:
  - Response: the scoreboard sees an in-order, lossless output sequence.
  - ReadyE never depends combinationally on ReadyM.

Source files
------------

// File: rtl/em_skid_stage.sv
// EX/MEM boundary register with valid/ready handshake and a two-entry skid buffer.
// ReadyE comes straight from a flop, so memory-stage stalls never form a combinational path into execute.
module em_skid_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int RSRC_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              FlushM,
    input  logic              ValidE,
    output logic              ReadyE,
    input  logic              RegWriteE,
    input  logic              MemWriteE,
    input  logic [RSRC_W-1:0] ResultSrcE,
    input  logic [XLEN-1:0]   ALUResultE,
    input  logic [XLEN-1:0]   WriteDataE,
    input  logic [XLEN-1:0]   PCPlus4E,
    input  logic [REG_AW-1:0] RdE,
    output logic              ValidM,
    input  logic              ReadyM,
    output logic              RegWriteM,
    output logic              MemWriteM,
    output logic [RSRC_W-1:0] ResultSrcM,
    output logic [XLEN-1:0]   ALUResultM,
    output logic [XLEN-1:0]   WriteDataM,
    output logic [XLEN-1:0]   PCPlus4M,
    output logic [REG_AW-1:0] RdM,
    output logic [1:0]        OccM
);

    typedef struct packed {
        logic              regwrite;
        logic              memwrite;
        logic [RSRC_W-1:0] resultsrc;
        logic [XLEN-1:0]   alu;
        logic [XLEN-1:0]   wdata;
        logic [XLEN-1:0]   pcplus4;
        logic [REG_AW-1:0] rd;
    } ent_t;

    ent_t ent_e, main_q, skid_q;
    logic mv, sv, ready_q;
    logic accept, consume;

    assign ent_e   = '{regwrite: RegWriteE, memwrite: MemWriteE, resultsrc: ResultSrcE,
                       alu: ALUResultE, wdata: WriteDataE, pcplus4: PCPlus4E, rd: RdE};
    assign accept  = ValidE & ready_q;
    assign consume = mv & ReadyM;

    // ready_q always tracks ~sv; it is a separate flop so ReadyE has no logic in front of it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mv      <= 1'b0;
            sv      <= 1'b0;
            ready_q <= 1'b1;
            main_q  <= '0;
            skid_q  <= '0;
        end else if (FlushM) begin
            mv      <= 1'b0;
            sv      <= 1'b0;
            ready_q <= 1'b1;
        end else if (!mv) begin
            if (accept) begin
                main_q <= ent_e;
                mv     <= 1'b1;
            end
        end else if (!sv) begin
            if (consume) begin
                if (accept) main_q <= ent_e;
                else        mv     <= 1'b0;
            end else if (accept) begin
                skid_q  <= ent_e;
                sv      <= 1'b1;
                ready_q <= 1'b0;
            end
        end else if (consume) begin
            main_q  <= skid_q;
            sv      <= 1'b0;
            ready_q <= 1'b1;
        end
    end

    assign ReadyE     = ready_q;
    assign ValidM     = mv;
    assign RegWriteM  = main_q.regwrite & mv;
    assign MemWriteM  = main_q.memwrite & mv;
    assign ResultSrcM = main_q.resultsrc;
    assign ALUResultM = main_q.alu;
    assign WriteDataM = main_q.wdata;
    assign PCPlus4M   = main_q.pcplus4;
    assign RdM        = main_q.rd;
    assign OccM       = {1'b0, mv} + {1'b0, sv};

endmodule

// File: tb/tb_em_skid_stage.sv
// Directed scenarios plus a randomised run against a 2-deep FIFO reference model.
module tb_em_skid_stage;

    logic        clk, rst_n, FlushM, ValidE, ReadyE, RegWriteE, MemWriteE;
    logic [1:0]  ResultSrcE, ResultSrcM, OccM;
    logic [31:0] ALUResultE, WriteDataE, PCPlus4E, ALUResultM, WriteDataM, PCPlus4M;
    logic [4:0]  RdE, RdM;
    logic        ValidM, ReadyM, RegWriteM, MemWriteM;

    int checks = 0;
    int fails  = 0;

    typedef struct packed {
        logic        rw;
        logic        mw;
        logic [1:0]  rs;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [31:0] pc;
        logic [4:0]  rd;
    } ent_t;

    em_skid_stage #(.XLEN(32), .REG_AW(5), .RSRC_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .FlushM(FlushM), .ValidE(ValidE), .ReadyE(ReadyE),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
        .ALUResultE(ALUResultE), .WriteDataE(WriteDataE), .PCPlus4E(PCPlus4E), .RdE(RdE),
        .ValidM(ValidM), .ReadyM(ReadyM), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
        .ResultSrcM(ResultSrcM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .PCPlus4M(PCPlus4M), .RdM(RdM), .OccM(OccM)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [31:0] alu, input logic rw, input logic mw,
                         input logic [4:0] rd);
        ValidE     = v;
        ALUResultE = alu;
        WriteDataE = ~alu;
        PCPlus4E   = alu + 32'd4;
        ResultSrcE = alu[1:0];
        RegWriteE  = rw;
        MemWriteE  = mw;
        RdE        = rd;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; FlushM = 1'b0; ReadyM = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 5'd0);
        repeat (2) tick();
        checks++;
        if (ReadyE !== 1'b1 || ValidM !== 1'b0 || OccM !== 2'd0 || RegWriteM !== 1'b0 ||
            MemWriteM !== 1'b0 || ALUResultM !== 32'h0 || WriteDataM !== 32'h0 ||
            PCPlus4M !== 32'h0 || RdM !== 5'd0 || ResultSrcM !== 2'd0) begin
            fails++;
            $display("FAIL reset: got rdyE=%b vM=%b occ=%0d alu=%h, need 1 0 0 0", ReadyE, ValidM, OccM, ALUResultM);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_stream();
        logic [31:0] vals [3];
        vals[0] = 32'h10; vals[1] = 32'h20; vals[2] = 32'h30;
        ReadyM = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, vals[i], 1'b0, 1'b0, 5'd1);
            tick();
            checks++;
            if (ValidM !== 1'b1 || ALUResultM !== vals[i] || OccM !== 2'd1 || ReadyE !== 1'b1 ||
                WriteDataM !== ~vals[i] || PCPlus4M !== vals[i] + 32'd4) begin
                fails++;
                $display("FAIL stream[%0d]: got vM=%b alu=%h occ=%0d rdyE=%b, need 1 %h 1 1", i, ValidM, ALUResultM, OccM, ReadyE, vals[i]);
            end
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 5'd0);
        tick();
        checks++;
        if (ValidM !== 1'b0 || OccM !== 2'd0) begin
            fails++;
            $display("FAIL stream_drain: got vM=%b occ=%0d, need 0 0", ValidM, OccM);
        end
    endtask

    task automatic test_skid();
        logic [31:0] exp_out [4];
        exp_out[0] = 32'hA; exp_out[1] = 32'hB; exp_out[2] = 32'hC; exp_out[3] = 32'hD;
        ReadyM = 1'b0;
        drive(1'b1, 32'hA, 1'b0, 1'b0, 5'd2);
        tick();
        checks++;
        if (ValidM !== 1'b1 || ALUResultM !== 32'hA || OccM !== 2'd1 || ReadyE !== 1'b1) begin
            fails++;
            $display("FAIL skid_land: got vM=%b alu=%h occ=%0d rdyE=%b, need 1 a 1 1", ValidM, ALUResultM, OccM, ReadyE);
        end
        drive(1'b1, 32'hB, 1'b0, 1'b0, 5'd2);
        tick();
        checks++;
        if (ALUResultM !== 32'hA || OccM !== 2'd2 || ReadyE !== 1'b0) begin
            fails++;
            $display("FAIL skid_fill: got alu=%h occ=%0d rdyE=%b, need a 2 0", ALUResultM, OccM, ReadyE);
        end
        drive(1'b1, 32'hC, 1'b0, 1'b0, 5'd2);
        tick();
        checks++;
        if (ALUResultM !== 32'hA || OccM !== 2'd2 || ReadyE !== 1'b0) begin
            fails++;
            $display("FAIL skid_hold: got alu=%h occ=%0d rdyE=%b, need a 2 0", ALUResultM, OccM, ReadyE);
        end
        ReadyM = 1'b1;
        // First release edge drains skid into main; C still waits on ReadyE recovering.
        tick();
        checks++;
        if (ALUResultM !== 32'hB || OccM !== 2'd1 || ReadyE !== 1'b1) begin
            fails++;
            $display("FAIL skid_drain: got alu=%h occ=%0d rdyE=%b, need b 1 1", ALUResultM, OccM, ReadyE);
        end
        tick();
        checks++;
        if (ValidM !== 1'b1 || ALUResultM !== exp_out[2]) begin
            fails++;
            $display("FAIL skid_outC: got vM=%b alu=%h, need 1 %h", ValidM, ALUResultM, exp_out[2]);
        end
        drive(1'b1, 32'hD, 1'b0, 1'b0, 5'd2);
        tick();
        checks++;
        if (ValidM !== 1'b1 || ALUResultM !== exp_out[3]) begin
            fails++;
            $display("FAIL skid_outD: got vM=%b alu=%h, need 1 %h", ValidM, ALUResultM, exp_out[3]);
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 5'd0);
        tick();
        checks++;
        if (ValidM !== 1'b0 || OccM !== 2'd0) begin
            fails++;
            $display("FAIL skid_empty: got vM=%b occ=%0d, need 0 0", ValidM, OccM);
        end
    endtask

    task automatic test_gating();
        ReadyM = 1'b1;
        drive(1'b0, 32'h55, 1'b1, 1'b1, 5'd5);
        tick();
        checks++;
        if (ValidM !== 1'b0 || RegWriteM !== 1'b0 || MemWriteM !== 1'b0) begin
            fails++;
            $display("FAIL gate_invalid: got vM=%b rw=%b mw=%b, need 0 0 0", ValidM, RegWriteM, MemWriteM);
        end
        drive(1'b1, 32'h55, 1'b1, 1'b1, 5'd5);
        tick();
        checks++;
        if (ValidM !== 1'b1 || RegWriteM !== 1'b1 || MemWriteM !== 1'b1 || RdM !== 5'd5) begin
            fails++;
            $display("FAIL gate_valid: got vM=%b rw=%b mw=%b rd=%0d, need 1 1 1 5", ValidM, RegWriteM, MemWriteM, RdM);
        end
        drive(1'b0, 32'h0, 1'b1, 1'b1, 5'd5);
        tick();
        checks++;
        if (ValidM !== 1'b0 || RegWriteM !== 1'b0 || MemWriteM !== 1'b0) begin
            fails++;
            $display("FAIL gate_stale: got vM=%b rw=%b mw=%b, need 0 0 0", ValidM, RegWriteM, MemWriteM);
        end
    endtask

    task automatic test_flush();
        ReadyM = 1'b0;
        drive(1'b1, 32'h100, 1'b1, 1'b1, 5'd3);
        tick();
        drive(1'b1, 32'h200, 1'b1, 1'b1, 5'd3);
        tick();
        checks++;
        if (OccM !== 2'd2) begin
            fails++;
            $display("FAIL flush_fill: got occ=%0d, need 2", OccM);
        end
        drive(1'b1, 32'h300, 1'b1, 1'b1, 5'd3);
        FlushM = 1'b1; ReadyM = 1'b1;
        tick();
        checks++;
        if (ValidM !== 1'b0 || OccM !== 2'd0 || ReadyE !== 1'b1 || MemWriteM !== 1'b0 || RegWriteM !== 1'b0) begin
            fails++;
            $display("FAIL flush: got vM=%b occ=%0d rdyE=%b mw=%b, need 0 0 1 0", ValidM, OccM, ReadyE, MemWriteM);
        end
        FlushM = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 5'd0);
        tick();
        checks++;
        if (ValidM !== 1'b0 || OccM !== 2'd0) begin
            fails++;
            $display("FAIL flush_dropped: got vM=%b occ=%0d alu=%h, need 0 0", ValidM, OccM, ALUResultM);
        end
        // Flush while ReadyE=1: handshake completes but the entry is dropped.
        drive(1'b1, 32'h400, 1'b1, 1'b1, 5'd3);
        FlushM = 1'b1;
        tick();
        FlushM = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 5'd0);
        checks++;
        if (ValidM !== 1'b0 || OccM !== 2'd0 || ReadyE !== 1'b1) begin
            fails++;
            $display("FAIL flush_offered: got vM=%b occ=%0d rdyE=%b, need 0 0 1", ValidM, OccM, ReadyE);
        end
    endtask

    task automatic test_async_reset();
        ReadyM = 1'b0;
        drive(1'b1, 32'hDEAD_0001, 1'b1, 1'b1, 5'd7);
        tick();
        drive(1'b1, 32'hDEAD_0002, 1'b1, 1'b1, 5'd7);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 5'd0);
        checks++;
        if (OccM !== 2'd2 || ALUResultM !== 32'hDEAD_0001) begin
            fails++;
            $display("FAIL areset_fill: got occ=%0d alu=%h, need 2 dead0001", OccM, ALUResultM);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (ValidM !== 1'b0 || OccM !== 2'd0 || ReadyE !== 1'b1 || ALUResultM !== 32'h0 ||
            WriteDataM !== 32'h0 || PCPlus4M !== 32'h0 || RdM !== 5'd0 || RegWriteM !== 1'b0 ||
            MemWriteM !== 1'b0 || ResultSrcM !== 2'd0) begin
            fails++;
            $display("FAIL areset: got vM=%b occ=%0d rdyE=%b alu=%h wd=%h, need 0 0 1 0 0", ValidM, OccM, ReadyE, ALUResultM, WriteDataM);
        end
        #1 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_random();
        ent_t q[$];
        ent_t cur;
        ent_t exp_e;
        logic v, rm, fl, acc, con, r0;
        int   n_ok = 1;
        v = 1'b0; cur = '0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            checks++;
            if (ValidM !== (q.size() > 0) || ReadyE !== (q.size() < 2) || OccM !== q.size()) begin
                fails++; n_ok = 0;
                $display("FAIL rand_state@%0d: got vM=%b rdyE=%b occ=%0d, need occ=%0d", cyc, ValidM, ReadyE, OccM, q.size());
            end else if (q.size() > 0) begin
                exp_e = q[0];
                checks++;
                if (ALUResultM !== exp_e.alu || WriteDataM !== exp_e.wd || PCPlus4M !== exp_e.pc ||
                    RdM !== exp_e.rd || ResultSrcM !== exp_e.rs || RegWriteM !== exp_e.rw ||
                    MemWriteM !== exp_e.mw) begin
                    fails++;
                    $display("FAIL rand_data@%0d: got alu=%h rd=%0d rw=%b mw=%b, need %h %0d %b %b", cyc, ALUResultM, RdM, RegWriteM, MemWriteM, exp_e.alu, exp_e.rd, exp_e.rw, exp_e.mw);
                end
            end else begin
                checks++;
                if (RegWriteM !== 1'b0 || MemWriteM !== 1'b0) begin
                    fails++;
                    $display("FAIL rand_gate@%0d: got rw=%b mw=%b, need 0 0", cyc, RegWriteM, MemWriteM);
                end
            end
            if (n_ok == 0) break;
            // Producer must hold a stalled offer; otherwise pick a fresh one.
            if (!(v && q.size() >= 2)) begin
                v   = ($urandom_range(0, 9) < 7);
                cur = '{rw: 1'($urandom), mw: 1'($urandom), rs: 2'($urandom), alu: $urandom,
                        wd: $urandom, pc: $urandom, rd: 5'($urandom)};
            end
            rm = ($urandom_range(0, 9) < 6);
            fl = ($urandom_range(0, 63) == 0);
            ValidE = v; RegWriteE = cur.rw; MemWriteE = cur.mw; ResultSrcE = cur.rs;
            ALUResultE = cur.alu; WriteDataE = cur.wd; PCPlus4E = cur.pc; RdE = cur.rd;
            ReadyM = rm; FlushM = fl;
            if (cyc % 16 == 0) begin
                #1 r0 = ReadyE;
                ReadyM = ~rm;
                #1;
                checks++;
                if (ReadyE !== r0) begin
                    fails++;
                    $display("FAIL rand_readyE_comb@%0d: got %b, need %b", cyc, ReadyE, r0);
                end
                ReadyM = rm;
            end
            acc = v && (q.size() < 2);
            con = (q.size() > 0) && rm;
            if (fl) q.delete();
            else begin
                if (con) void'(q.pop_front());
                if (acc) q.push_back(cur);
            end
            tick();
        end
        ValidE = 1'b0; FlushM = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_skid();
        test_gating();
        test_flush();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
